// File: rtl/ram_bus_pkg.sv
// Shared types for the single-port RAM initiator: width defaults, FSM states, strobe encodings.
// RAM_MASTER_VERIFY_EN adds the write-verify states.
package ram_bus_pkg;

  localparam int unsigned AddrWDefault = 8;
  localparam int unsigned DataWDefault = 64;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdIssue,
    StRdCapt,
    StRdHold,
    StDone
`ifdef RAM_MASTER_VERIFY_EN
    ,
    StVfyRd,
    StVfyCmp
`endif
  } state_e;

  typedef struct packed {
    logic cen;
    logic wen;
  } strobe_t;

  localparam strobe_t StrobeIdle  = '{cen: 1'b0, wen: 1'b0};
  localparam strobe_t StrobeWrite = '{cen: 1'b1, wen: 1'b1};
  localparam strobe_t StrobeRead  = '{cen: 1'b1, wen: 1'b0};

endpackage

// File: rtl/ram_master.sv
// Burst initiator for the 64x256 single-port synchronous RAM with stream-style data ports.
// Optional read-after-write verify with sticky err is enabled by defining RAM_MASTER_VERIFY_EN.
module ram_master
  import ram_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              m_cen,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_din,
  input  logic [DATA_W-1:0] m_dout
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  strobe_t           strb_q, strb_d;
  logic [ADDR_W-1:0] m_addr_d;
  logic [DATA_W-1:0] m_din_d;
  logic [DATA_W-1:0] rdata_d;
  logic              rdata_valid_d;
  logic              done_d;

`ifdef RAM_MASTER_VERIFY_EN
  logic err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready   = (state_q == StIdle);
  assign wdata_ready = (state_q == StWr);
  assign busy        = (state_q != StIdle);
  assign m_cen       = strb_q.cen;
  assign m_wen       = strb_q.wen;
  // done trails the DONE state so it lands one cycle after the final write strobe
  assign done_d      = (state_q == StDone);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    strb_d        = StrobeIdle;
    m_addr_d      = m_addr;
    m_din_d       = m_din;
    rdata_d       = rdata;
    rdata_valid_d = rdata_valid;
`ifdef RAM_MASTER_VERIFY_EN
    err_d         = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          cnt_d  = cmd_len;
`ifdef RAM_MASTER_VERIFY_EN
          err_d  = 1'b0;
`endif
          if (cmd_wr) begin
            state_d = StWr;
          end else begin
            state_d  = StRdIssue;
            strb_d   = StrobeRead;
            m_addr_d = cmd_addr;
          end
        end
      end
      StWr: begin
        if (wdata_valid) begin
          strb_d   = StrobeWrite;
          m_addr_d = addr_q;
          m_din_d  = wdata;
          addr_d   = addr_q + ADDR_W'(1);
`ifdef RAM_MASTER_VERIFY_EN
          state_d  = StVfyRd;
`else
          if (cnt_q == '0) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - ADDR_W'(1);
          end
`endif
        end
      end
      StRdIssue: state_d = StRdCapt;
      StRdCapt: begin
        rdata_d       = m_dout;
        rdata_valid_d = 1'b1;
        state_d       = StRdHold;
      end
      StRdHold: begin
        if (rdata_ready) begin
          rdata_valid_d = 1'b0;
          addr_d        = addr_q + ADDR_W'(1);
          if (cnt_q == '0) begin
            state_d = StDone;
          end else begin
            cnt_d    = cnt_q - ADDR_W'(1);
            strb_d   = StrobeRead;
            m_addr_d = addr_q + ADDR_W'(1);
            state_d  = StRdIssue;
          end
        end
      end
      StDone: state_d = StIdle;
`ifdef RAM_MASTER_VERIFY_EN
      // First cycle shows the write strobe and schedules the read-back at the same address.
      StVfyRd: begin
        if (strb_q.wen) begin
          strb_d = StrobeRead;
        end else begin
          state_d = StVfyCmp;
        end
      end
      StVfyCmp: begin
        if (m_dout != m_din) err_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q - ADDR_W'(1);
          state_d = StWr;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      cnt_q       <= '0;
      strb_q      <= StrobeIdle;
      m_addr      <= '0;
      m_din       <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      strb_q      <= strb_d;
      m_addr      <= m_addr_d;
      m_din       <= m_din_d;
      rdata       <= rdata_d;
      rdata_valid <= rdata_valid_d;
      done        <= done_d;
    end
  end

`ifdef RAM_MASTER_VERIFY_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master with a behavioural model of the synchronous RAM.
module tb_ram_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [7:0]  cmd_addr, cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [63:0] wdata;
  logic        rdata_valid, rdata_ready;
  logic [63:0] rdata;
  logic        busy, done, err;
  logic        m_cen, m_wen;
  logic [7:0]  m_addr;
  logic [63:0] m_din;
  logic [63:0] m_dout = '0;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] mem [256];
  logic [63:0] wq [4];
  int          cyc = 0;
  int          st_cyc [$];
  logic        st_wen [$];
  logic [7:0]  st_addr [$];
  logic [63:0] st_din [$];
  int          wh_cyc [$];
  int          rh_cyc [$];
  logic [63:0] rh_data [$];
  int          rv_cyc [$];
  int          dn_cyc [$];
  logic        rv_prev = 1'b0;

  always #5 clk = ~clk;

  ram_master dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .rdata       (rdata),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .m_cen       (m_cen),
    .m_wen       (m_wen),
    .m_addr      (m_addr),
    .m_din       (m_din),
    .m_dout      (m_dout)
  );

  // RAM model plus event log; values seen here are those held during the cycle ending at this edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_cen) begin
      st_cyc.push_back(cyc);
      st_wen.push_back(m_wen);
      st_addr.push_back(m_addr);
      st_din.push_back(m_din);
    end
    if (m_cen && m_wen) mem[m_addr] <= m_din;
    m_dout <= (m_cen && !m_wen) ? mem[m_addr] : 64'd0;
    if (wdata_valid && wdata_ready) wh_cyc.push_back(cyc);
    if (rdata_valid && rdata_ready) begin
      rh_cyc.push_back(cyc);
      rh_data.push_back(rdata);
    end
    if (rdata_valid && !rv_prev) rv_cyc.push_back(cyc);
    rv_prev <= rdata_valid;
    if (done) dn_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    st_cyc.delete(); st_wen.delete(); st_addr.delete(); st_din.delete();
    wh_cyc.delete(); rh_cyc.delete(); rh_data.delete(); rv_cyc.delete(); dn_cyc.delete();
  endtask

  task automatic issue_cmd(input logic wr, input logic [7:0] a, input logic [7:0] len);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic [7:0] a, input logic [7:0] len, input int n_hs,
                           input int stall_at);
    int  i = 0;
    int  g = 0;
    logic hs;
    issue_cmd(1'b1, a, len);
    while (i < n_hs && g < 200) begin
      wdata_valid = (g != stall_at);
      wdata       = wq[i];
      hs          = wdata_valid && wdata_ready;
      tick();
      if (hs) i++;
      g++;
    end
    wdata_valid = 1'b0;
    check("wr_handshakes", 64'(i), 64'(n_hs));
  endtask

  task automatic run_read(input logic [7:0] a, input logic [7:0] len, input int hold,
                          input logic [63:0] hold_exp);
    int  got = 0;
    int  g = 0;
    int  held = 0;
    logic hs;
    issue_cmd(1'b0, a, len);
    while (got < int'(len) + 1 && g < 200) begin
      rdata_ready = (held >= hold);
      if (rdata_valid && !rdata_ready) begin
        check("hold_rdata", rdata, hold_exp);
        check("hold_no_strobe", 64'(st_cyc.size()), 1);
        held++;
      end
      hs = rdata_valid && rdata_ready;
      tick();
      if (hs) got++;
      g++;
    end
    rdata_ready = 1'b0;
    check("rd_handshakes", 64'(got), 64'(int'(len) + 1));
    if (hold > 0) check("hold_cycles", 64'(held), 64'(hold));
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!cmd_ready && g < 100) begin
      tick();
      g++;
    end
    check("idle_reached", cmd_ready, 1);
    repeat (2) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 0; cmd_wr = 0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 0; wdata = '0; rdata_ready = 0;
    repeat (3) tick();
    check("rst_m_cen", m_cen, 0);
    check("rst_m_wen", m_wen, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_din", m_din, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wdata_ready", wdata_ready, 0);
    rst = 1'b0;
    tick();

    // 4-word write at 0x10, data held valid
    wq[0] = 64'h1111_1111_1111_1111; wq[1] = 64'h2222_2222_2222_2222;
    wq[2] = 64'h3333_3333_3333_3333; wq[3] = 64'h4444_4444_4444_4444;
    clear_log();
    run_write(8'h10, 8'd3, 4, -1);
    check("wr_busy", busy, 1);
    wait_idle();
    check("wr_strobe_count", 64'(st_cyc.size()), 4);
    for (int i = 0; i < 4 && i < st_cyc.size() && i < wh_cyc.size(); i++) begin
      check("wr_addr", st_addr[i], 64'(8'h10 + i));
      check("wr_wen", st_wen[i], 1);
      check("wr_din", st_din[i], wq[i]);
      check("wr_strobe_lag", 64'(st_cyc[i]), 64'(wh_cyc[i] + 1));
      check("wr_back_to_back", 64'(st_cyc[i]), 64'(st_cyc[0] + i));
    end
    check("wr_done_count", 64'(dn_cyc.size()), 1);
    if (dn_cyc.size() > 0 && st_cyc.size() == 4) check("wr_done_time", 64'(dn_cyc[0]), 64'(st_cyc[3] + 1));

    // 4-word read back at 0x10, no backpressure
    clear_log();
    run_read(8'h10, 8'd3, 0, '0);
    wait_idle();
    check("rd_strobe_count", 64'(st_cyc.size()), 4);
    for (int i = 0; i < 4 && i < st_cyc.size() && i < rh_data.size() && i < rv_cyc.size(); i++) begin
      check("rd_data", rh_data[i], {8{8'(8'h11 * (i + 1))}});
      check("rd_addr", st_addr[i], 64'(8'h10 + i));
      check("rd_wen", st_wen[i], 0);
      check("rd_latency", 64'(rv_cyc[i]), 64'(st_cyc[i] + 2));
    end
    check("rd_done_count", 64'(dn_cyc.size()), 1);
    if (dn_cyc.size() > 0 && rh_cyc.size() == 4) check("rd_done_time", 64'(dn_cyc[0]), 64'(rh_cyc[3] + 2));

    // Read with 5 cycles of backpressure on the first word
    clear_log();
    run_read(8'h10, 8'd1, 5, 64'h1111_1111_1111_1111);
    wait_idle();
    check("bp_strobe_count", 64'(st_cyc.size()), 2);
    if (rh_data.size() == 2) begin
      check("bp_data0", rh_data[0], 64'h1111_1111_1111_1111);
      check("bp_data1", rh_data[1], 64'h2222_2222_2222_2222);
    end

    // Address wrap with a one-cycle wdata stall
    wq[0] = 64'hAAAA_0000_0000_00FE; wq[1] = 64'hBBBB_0000_0000_00FF;
    wq[2] = 64'hCCCC_0000_0000_0000;
    clear_log();
    run_write(8'hFE, 8'd2, 3, 1);
    wait_idle();
    check("wrap_strobe_count", 64'(st_cyc.size()), 3);
    if (st_addr.size() == 3) begin
      check("wrap_addr0", st_addr[0], 8'hFE);
      check("wrap_addr1", st_addr[1], 8'hFF);
      check("wrap_addr2", st_addr[2], 8'h00);
      check("wrap_din2", st_din[2], wq[2]);
    end
    check("wrap_done_count", 64'(dn_cyc.size()), 1);

    // Reset in the middle of a 4-word write
    wq[0] = 64'h0123_4567_89AB_CDEF; wq[1] = 64'hFEDC_BA98_7654_3210;
    clear_log();
    run_write(8'h20, 8'd3, 2, -1);
    rst = 1'b1;
    tick();
    check("abort_m_cen", m_cen, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    repeat (4) tick();
    check("abort_no_done", 64'(dn_cyc.size()), 0);
    check("abort_strobes", 64'(st_cyc.size()), 2);
    clear_log();
    run_read(8'h20, 8'd1, 0, '0);
    wait_idle();
    if (rh_data.size() == 2) begin
      check("abort_persist0", rh_data[0], 64'h0123_4567_89AB_CDEF);
      check("abort_persist1", rh_data[1], 64'hFEDC_BA98_7654_3210);
    end
    check("final_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
